// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small write FIFO. Each frame is a start bit, DATA_W data bits
// sent LSB first, an optional parity bit and STOP_BITS stop bits, each CLKS_PER_BIT clocks long.
module uart_tx_fifo #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_W-1:0]               data,
   input  logic                            en_tx,
   output logic                            tx_ready,
   output logic                            u_tx,
   output logic                            u_tx_done,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_W - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [2:0]        state;
   logic [BW-1:0]     baud_cnt;
   logic [IW-1:0]     bit_idx;
   logic              stop_idx;
   logic [DATA_W-1:0] shift_reg;
   logic              par_bit;
   logic [DATA_W-1:0] head;
   logic              full;
   logic              push;
   logic              pop;
   logic              baud_end;
   logic              stop_end;

   assign full      = (fifo_count == CNT_FULL);
   assign push      = en_tx && !full;
   assign baud_end  = (baud_cnt == BAUD_LAST);
   assign stop_end  = (state == S_STOP) && baud_end && (stop_idx == STOP_LAST);
   // A pop happens from IDLE or on the last stop cycle, so back-to-back frames have no gap.
   assign pop       = (fifo_count != '0) && ((state == S_IDLE) || stop_end);
   assign head      = mem[rd_ptr];
   assign tx_ready  = !full;
   assign busy      = (state != S_IDLE);
   assign u_tx_done = stop_end;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_count <= fifo_count + CW'(1);
         else if (pop && !push) fifo_count <= fifo_count - CW'(1);
         if (en_tx && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         u_tx      <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift_reg <= '0;
         par_bit   <= 1'b0;
      end else if (pop) begin
         state     <= S_START;
         u_tx      <= 1'b0;
         baud_cnt  <= '0;
         shift_reg <= head;
         par_bit   <= (PARITY == 1) ? ~(^head) : (^head);
      end else if (state == S_IDLE) begin
         u_tx     <= 1'b1;
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
         if (baud_end) begin
            case (state)
               S_START: begin
                  state   <= S_DATA;
                  bit_idx <= '0;
                  u_tx    <= shift_reg[0];
               end
               S_DATA: begin
                  if (bit_idx == BIT_LAST) begin
                     if (PARITY != 0) begin
                        state <= S_PAR;
                        u_tx  <= par_bit;
                     end else begin
                        state    <= S_STOP;
                        u_tx     <= 1'b1;
                        stop_idx <= 1'b0;
                     end
                  end else begin
                     bit_idx   <= bit_idx + IW'(1);
                     shift_reg <= shift_reg >> 1;
                     u_tx      <= shift_reg[1];
                  end
               end
               S_PAR: begin
                  state    <= S_STOP;
                  u_tx     <= 1'b1;
                  stop_idx <= 1'b0;
               end
               S_STOP: begin
                  if (stop_idx == STOP_LAST) begin
                     state <= S_IDLE;
                     u_tx  <= 1'b1;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  u_tx  <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations side by side, a frame-level reference model,
// a table of known frames and hand sequences for back-to-back, overflow and mid-frame reset.
module tb_uart_tx_fifo;

   localparam int NI    = 4;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] data_v     [NI];
   logic       en_v       [NI];
   logic       tx_ready_v [NI];
   logic       u_tx_v     [NI];
   logic       done_v     [NI];
   logic       busy_v     [NI];
   logic       ovf_v      [NI];
   logic [2:0] cnt_v      [NI];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) d0 (
      .clk(clk), .rst(rst), .data(data_v[0][7:0]), .en_tx(en_v[0]), .tx_ready(tx_ready_v[0]),
      .u_tx(u_tx_v[0]), .u_tx_done(done_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]), .overflow(ovf_v[0]));
   uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) d1 (
      .clk(clk), .rst(rst), .data(data_v[1][7:0]), .en_tx(en_v[1]), .tx_ready(tx_ready_v[1]),
      .u_tx(u_tx_v[1]), .u_tx_done(done_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]), .overflow(ovf_v[1]));
   uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) d2 (
      .clk(clk), .rst(rst), .data(data_v[2][7:0]), .en_tx(en_v[2]), .tx_ready(tx_ready_v[2]),
      .u_tx(u_tx_v[2]), .u_tx_done(done_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]), .overflow(ovf_v[2]));
   uart_tx_fifo #(.DATA_W(5), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) d3 (
      .clk(clk), .rst(rst), .data(data_v[3][4:0]), .en_tx(en_v[3]), .tx_ready(tx_ready_v[3]),
      .u_tx(u_tx_v[3]), .u_tx_done(done_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]), .overflow(ovf_v[3]));

   function automatic int dw_of(input int i);
      return (i == 3) ? 5 : 8;
   endfunction
   function automatic int par_of(input int i);
      return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
   endfunction
   function automatic int sb_of(input int i);
      return (i == 3) ? 2 : 1;
   endfunction
   function automatic int flen(input int i);
      return (1 + dw_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i)) * CPB;
   endfunction
   function automatic logic [8:0] mask_of(input int i);
      return (i == 3) ? 9'h01F : 9'h0FF;
   endfunction

   // Line level of bit b of a frame carrying word w.
   function automatic logic frame_bit(input int i, input logic [8:0] w, input int b);
      int ones;
      ones = $countones(w);
      if (b == 0) return 1'b0;
      if (b <= dw_of(i)) return w[b-1];
      if (par_of(i) != 0 && b == dw_of(i) + 1)
         return (par_of(i) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      return 1'b1;
   endfunction

   task automatic chk(input string name, input int inst, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s inst=%0d actual=%0h expected=%0h time=%0t", name, inst, act, exp, $time);
      end
   endtask

   // Reference model: queue of pending words plus the frame currently on the line.
   logic [8:0] mq [NI][$];
   logic [8:0] m_word [NI];
   int         m_pos  [NI];
   bit         m_busy [NI];
   bit         m_ovf  [NI];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            m_busy[i] = 1'b0;
            m_pos[i]  = 0;
            m_ovf[i]  = 1'b0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            int avail;
            avail = mq[i].size();
            if (m_busy[i]) begin
               m_pos[i]++;
               if (m_pos[i] == flen(i)) m_busy[i] = 1'b0;
            end
            if (!m_busy[i] && avail > 0) begin
               m_word[i] = mq[i].pop_front();
               m_busy[i] = 1'b1;
               m_pos[i]  = 0;
            end
            if (en_v[i]) begin
               if (avail < DEPTH) mq[i].push_back(data_v[i] & mask_of(i));
               else m_ovf[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         logic exp_tx;
         exp_tx = m_busy[i] ? frame_bit(i, m_word[i], m_pos[i] / CPB) : 1'b1;
         chk("model_u_tx", i, u_tx_v[i], exp_tx);
         chk("model_done", i, done_v[i], (m_busy[i] && m_pos[i] == flen(i) - 1) ? 1 : 0);
         chk("model_busy", i, busy_v[i], m_busy[i]);
         chk("model_count", i, cnt_v[i], mq[i].size());
         chk("model_ready", i, tx_ready_v[i], (mq[i].size() < DEPTH) ? 1 : 0);
         chk("model_overflow", i, ovf_v[i], m_ovf[i]);
      end
   end

   typedef struct {
      int         inst;
      logic [8:0] word;
      logic [15:0] bits;
      int         nbits;
   } vec_t;

   vec_t vt [7];

   task automatic run_vec(input vec_t v);
      int t;
      int fl;
      t = 0;
      while ((busy_v[v.inst] || cnt_v[v.inst] != 0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("vec_idle_wait", v.inst, (t < 500) ? 1 : 0, 1);
      data_v[v.inst] = v.word;
      en_v[v.inst]   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en_v[v.inst]   = 1'b0;
      data_v[v.inst] = 9'($urandom);
      @(posedge clk);
      fl = v.nbits * CPB;
      for (int p = 0; p <= fl; p++) begin
         @(negedge clk);
         data_v[v.inst] = 9'($urandom);
         if (p % CPB == 1) chk("vec_bit", v.inst, u_tx_v[v.inst], v.bits[p / CPB]);
         if (p == fl - 2)  chk("vec_done_early", v.inst, done_v[v.inst], 0);
         if (p == fl - 1)  chk("vec_done_end", v.inst, done_v[v.inst], 1);
         if (p == fl)      chk("vec_busy_after", v.inst, busy_v[v.inst], 0);
      end
   endtask

   task automatic wait_idle0();
      int t;
      t = 0;
      while ((busy_v[0] || cnt_v[0] != 0) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("idle_wait", 0, (t < 1000) ? 1 : 0, 1);
   endtask

   initial begin
      int dt [$];
      int cyc;
      int nd;
      int probs [3];
      int prob;

      probs = '{5, 30, 90};
      prob  = 30;
      for (int i = 0; i < NI; i++) begin
         en_v[i]   = 1'b0;
         data_v[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_u_tx", i, u_tx_v[i], 1);
         chk("rst_done", i, done_v[i], 0);
         chk("rst_busy", i, busy_v[i], 0);
         chk("rst_count", i, cnt_v[i], 0);
         chk("rst_ready", i, tx_ready_v[i], 1);
         chk("rst_overflow", i, ovf_v[i], 0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Known frames, bit i of .bits is the i-th bit on the line.
      vt[0] = '{0, 9'h095, 16'h032A, 10};
      vt[1] = '{1, 9'h095, 16'h072A, 11};
      vt[2] = '{2, 9'h095, 16'h052A, 11};
      vt[3] = '{3, 9'h01F, 16'h00FE, 8};
      vt[4] = '{0, 9'h000, 16'h0200, 10};
      vt[5] = '{1, 9'h000, 16'h0600, 11};
      vt[6] = '{3, 9'h00A, 16'h00D4, 8};
      for (int k = 0; k < 7; k++) run_vec(vt[k]);

      // Three consecutive writes: contiguous frames, done pulses 40 cycles apart.
      wait_idle0();
      for (int k = 1; k <= 3; k++) begin
         data_v[0] = 9'(k);
         en_v[0]   = 1'b1;
         @(negedge clk);
      end
      en_v[0] = 1'b0;
      dt.delete();
      for (int c = 0; c < 200; c++) begin
         if (done_v[0]) dt.push_back(c);
         @(negedge clk);
      end
      chk("b2b_done_count", 0, dt.size(), 3);
      if (dt.size() == 3) begin
         chk("b2b_gap1", 0, dt[1] - dt[0], 40);
         chk("b2b_gap2", 0, dt[2] - dt[1], 40);
      end

      // Six consecutive writes: four queued, one dropped, five frames sent.
      wait_idle0();
      for (int k = 0; k < 6; k++) begin
         data_v[0] = 9'(8'h10 + k);
         en_v[0]   = 1'b1;
         @(negedge clk);
      end
      en_v[0] = 1'b0;
      chk("ovf_count", 0, cnt_v[0], 4);
      chk("ovf_ready", 0, tx_ready_v[0], 0);
      chk("ovf_flag", 0, ovf_v[0], 1);
      nd = 0;
      cyc = 0;
      while ((busy_v[0] || cnt_v[0] != 0) && cyc < 400) begin
         if (done_v[0]) nd++;
         @(negedge clk);
         cyc++;
      end
      chk("ovf_frames", 0, nd, 5);
      chk("ovf_sticky", 0, ovf_v[0], 1);

      // Reset in cycle 15 of a frame with two words queued.
      wait_idle0();
      for (int k = 0; k < 3; k++) begin
         data_v[0] = 9'(8'hA0 + k);
         en_v[0]   = 1'b1;
         @(negedge clk);
      end
      en_v[0] = 1'b0;
      chk("mid_rst_queued", 0, cnt_v[0], 2);
      repeat (13) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_u_tx", 0, u_tx_v[0], 1);
      chk("mid_rst_count", 0, cnt_v[0], 0);
      chk("mid_rst_busy", 0, busy_v[0], 0);
      chk("mid_rst_done", 0, done_v[0], 0);
      chk("mid_rst_ovf", 0, ovf_v[0], 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         chk("post_rst_idle", 0, u_tx_v[0], 1);
         chk("post_rst_nodone", 0, done_v[0], 0);
      end

      // Randomised traffic on all configurations, data wiggling every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c % 500 == 0) prob = probs[$urandom_range(0, 2)];
         if (c == 1500) #1 rst = 1'b1;
         if (c == 1503) rst = 1'b0;
         for (int i = 0; i < NI; i++) begin
            en_v[i]   = ($urandom_range(0, 99) < prob);
            data_v[i] = 9'($urandom);
         end
      end
      for (int i = 0; i < NI; i++) en_v[i] = 1'b0;
      repeat (500) @(negedge clk);
      for (int i = 0; i < NI; i++) chk("drain_idle", i, busy_v[i], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
